fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the accumulator CPU, sitting directly upstream of the control sequencer. Holds the program counter and the instruction register, and drives the instruction-memory address. Presents the decoded opcode and operand address to the control FSM and the datapath, and applies the control's PC-update strobes (increment, skip, jump) at writeback. Also keeps a sticky halt flag and a retired-instruction counter for debug.

## Interface
- ADDR_W, 5, width of PC, operand address and instruction-memory address
- OPC_W, 3, opcode width; instruction word is OPC_W+ADDR_W bits, opcode in the MSBs
- CNT_W, 16, width of the retired-instruction counter
- RST_PC, 0, PC value after reset

- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset; asynchronous assert, active-low; release synchronous to clk externally
- imem_rdata  in  OPC_W+ADDR_W  instruction word, combinational read of address pc_addr
- memIns_en  in  1  fetch strobe from control; IR captures imem_rdata on this edge
- pc_en  in  1  writeback strobe; PC updates on this edge
- pc_load  in  1  non-sequential PC update request (jump or taken skip)
- jmp  in  1  qualifies pc_load: 1 = jump, 0 = skip
- halt  in  1  halt request from control
- pc_addr  out  ADDR_W  current PC, drives instruction-memory address
- opcode  out  OPC_W  IR[MSB -: OPC_W], registered
- operand_addr  out  ADDR_W  IR[ADDR_W-1:0], registered; data-memory address and jump target
- ir_valid  out  1  set once IR has captured at least one instruction since reset
- halted  out  1  sticky halt flag
- retired  out  CNT_W  count of completed writebacks, saturating

## Operation
- Reset (rst_n=0, asynchronous): pc_addr=RST_PC, IR=0 (opcode=0, operand_addr=0), ir_valid=0, halted=0, retired=0. Reset mid-instruction discards everything immediately.
- Fetch: on a rising edge with memIns_en=1 and halted=0, IR <= imem_rdata, ir_valid <= 1. PC unchanged.
- Writeback: on a rising edge with pc_en=1 and halted=0:
  - pc_load=1, jmp=1: PC <= operand_addr (jump).
  - pc_load=1, jmp=0: PC <= PC+2 (skip taken; next instruction bypassed).
  - pc_load=0: PC <= PC+1.
  - retired <= retired+1, holding at 2^CNT_W-1 once reached.
- PC arithmetic is modulo 2^ADDR_W: PC = max wraps to 0 on +1; PC = max-1 wraps to 0 on +2; PC = max wraps to 1 on +2. No flag is raised on wrap.
- Halt: on any rising edge with halt=1, halted <= 1. Once halted=1, PC, IR and retired freeze and all strobes are ignored until reset. On an edge where halt=1 and pc_en=1 arrive together, halted sets and PC/retired do NOT update.
- memIns_en and pc_en on the same edge (illegal from control): both act; IR loads imem_rdata sampled at the old PC, and the PC update uses the old operand_addr.
- pc_load with pc_en=0 has no effect.
- halt has priority over all strobes; reset has priority over everything.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- opcode and operand_addr are valid the cycle after the fetch edge, so they are stable through decode, execute and writeback of a 4-state control sequence.
- PC update is visible on pc_addr one cycle after the writeback edge, ready for the next fetch.
- imem_rdata must settle within one cycle of pc_addr changing.
- Instruction latency is set by the control sequence. This block adds no wait states.

## Test plan
- Reset: drive rst_n=0 mid-run with PC=9. Require pc_addr=0, opcode=0, ir_valid=0, halted=0, retired=0 without a clock edge.
- Sequential fetch: imem holds words 0xA3 at address 0 and 0x41 at address 1, with four-cycle fetch/writeback strobes. Require opcode=5, operand_addr=3 after the first fetch. Require pc_addr=1 after the first writeback, then opcode=2, operand_addr=1.
- Jump: IR=0xFA (opcode 7, operand 26), pc_load=1, jmp=1, pc_en=1. Require pc_addr=26 and retired incremented by 1.
- Skip and wrap: PC=30, pc_load=1, jmp=0, pc_en=1 gives pc_addr=0. PC=31 with a plain pc_en gives pc_addr=0.
- Halt: halt=1 together with pc_en=1 at PC=4. Require halted=1 and pc_addr=4. Later memIns_en/pc_en pulses leave PC, IR and retired unchanged until rst_n pulses low.
- Counter saturation: with CNT_W=4, run 20 writebacks. Require retired=15 and holding.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the accumulator CPU: program counter, instruction
// register, sticky halt flag and saturating retired-instruction counter.
module fetch_unit #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned OPC_W  = 3,
    parameter int unsigned CNT_W  = 16,
    parameter logic [ADDR_W-1:0] RST_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OPC_W+ADDR_W-1:0] imem_rdata,
    input  logic                    memIns_en,
    input  logic                    pc_en,
    input  logic                    pc_load,
    input  logic                    jmp,
    input  logic                    halt,
    output logic [ADDR_W-1:0]       pc_addr,
    output logic [OPC_W-1:0]        opcode,
    output logic [ADDR_W-1:0]       operand_addr,
    output logic                    ir_valid,
    output logic                    halted,
    output logic [CNT_W-1:0]        retired
);

    localparam int unsigned IR_W = OPC_W + ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_next_s;
    logic [IR_W-1:0]   ir_r;
    logic [IR_W-1:0]   ir_next_s;
    logic              ir_valid_r;
    logic              ir_valid_next_s;
    logic              halted_r;
    logic              halted_next_s;
    logic [CNT_W-1:0]  retired_r;
    logic [CNT_W-1:0]  retired_next_s;
    logic              active_s;

    // Next-state logic: a pending or sticky halt blocks every strobe on this edge.
    always_comb begin
        pc_next_s       = pc_r;
        ir_next_s       = ir_r;
        ir_valid_next_s = ir_valid_r;
        halted_next_s   = halted_r;
        retired_next_s  = retired_r;
        active_s        = ~halted_r & ~halt;

        if (halt) begin
            halted_next_s = 1'b1;
        end else begin
            halted_next_s = halted_r;
        end

        if (active_s && memIns_en) begin
            ir_next_s       = imem_rdata;
            ir_valid_next_s = 1'b1;
        end else begin
            ir_next_s       = ir_r;
            ir_valid_next_s = ir_valid_r;
        end

        // Jump target comes from the IR as it stood before this edge.
        if (active_s && pc_en) begin
            case ({pc_load, jmp})
                2'b11:   pc_next_s = ir_r[ADDR_W-1:0];
                2'b10:   pc_next_s = pc_r + ADDR_W'(2);
                default: pc_next_s = pc_r + ADDR_W'(1);
            endcase
            if (retired_r == CNT_MAX) begin
                retired_next_s = retired_r;
            end else begin
                retired_next_s = retired_r + CNT_W'(1);
            end
        end else begin
            pc_next_s      = pc_r;
            retired_next_s = retired_r;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r       <= RST_PC;
            ir_r       <= '0;
            ir_valid_r <= 1'b0;
            halted_r   <= 1'b0;
            retired_r  <= '0;
        end else begin
            pc_r       <= pc_next_s;
            ir_r       <= ir_next_s;
            ir_valid_r <= ir_valid_next_s;
            halted_r   <= halted_next_s;
            retired_r  <= retired_next_s;
        end
    end

    assign pc_addr      = pc_r;
    assign opcode       = ir_r[IR_W-1 -: OPC_W];
    assign operand_addr = ir_r[ADDR_W-1:0];
    assign ir_valid     = ir_valid_r;
    assign halted       = halted_r;
    assign retired      = retired_r;

endmodule
